tape_dumper: RTL and testbench

// - Host-visible readback of the brainfuck data tape. Reads cells through the core's tape read port
//   (vga_data_addr / vga_cell), formats each as two upper-case ASCII hex digits and streams them to the

---
 rtl/tape_dumper_pkg.sv | 18 +
 rtl/tape_dumper_tx_char_sender.sv | 49 ++++
 rtl/tape_dumper.sv | 131 +++++++++++++
 tb/tb_tape_dumper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tape_dumper_pkg.sv
// Shared types and ASCII helpers for the tape dump streamer.
package tape_dumper_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_RD_LATCH, S_HI, S_LO, S_SEP, S_LF
  } state_t;

  typedef enum logic {TX_REQ, TX_ARM} tx_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/tape_dumper_tx_char_sender.sv
// One-character UART handshake: wait for an idle transmitter, pulse tx_start,
// then spend one blind cycle so the transmitter's busy flag has time to rise.
module tx_char_sender
  import tape_dumper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid_i,
  input  logic [7:0] char_i,
  input  logic       hold_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       char_accepted_o
);

  tx_state_t  state_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_REQ;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        TX_REQ: begin
          // hold_i blocks new starts; a char already in flight is left alone.
          if (char_valid_i && !tx_busy_i && !hold_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= char_i;
            state_q    <= TX_ARM;
          end
        end
        TX_ARM: begin
          tx_start_q <= 1'b0;
          state_q    <= TX_REQ;
        end
        default: state_q <= TX_REQ;
      endcase
    end
  end

  assign tx_start_o      = tx_start_q;
  assign tx_data_o       = tx_data_q;
  assign char_accepted_o = (state_q == TX_ARM);

endmodule

// File: rtl/tape_dumper.sv
// Reads tape cells and streams them as "HH HH ...\r\n" hex text to the UART.
// Runs only while the core is halted; cpu_executing aborts a running dump.
module tape_dumper
  import tape_dumper_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  input  logic [14:0] dump_base,
  input  logic [15:0] dump_len,
  input  logic        cpu_executing,
  output logic [14:0] tape_addr,
  input  logic [7:0]  tape_cell,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

  state_t      state_q;
  logic [14:0] addr_q;
  logic [15:0] remaining_q;
  logic [7:0]  line_ctr_q;
  logic [7:0]  byte_q;
  logic        busy_q, done_q, aborted_q;

  logic        char_valid, char_accepted, eol;
  logic [7:0]  char_d;

  assign eol = (line_ctr_q == LAST_COL) || (remaining_q == 16'd1);

  always_comb begin
    char_valid = 1'b0;
    char_d     = ASCII_SPACE;
    case (state_q)
      S_HI:    begin char_valid = 1'b1; char_d = nibble_to_ascii(byte_q[7:4]); end
      S_LO:    begin char_valid = 1'b1; char_d = nibble_to_ascii(byte_q[3:0]); end
      S_SEP:   begin char_valid = 1'b1; char_d = eol ? ASCII_CR : ASCII_SPACE; end
      S_LF:    begin char_valid = 1'b1; char_d = ASCII_LF; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      line_ctr_q  <= '0;
      byte_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state_q != S_IDLE && cpu_executing) begin
        aborted_q <= 1'b1;
        busy_q    <= 1'b0;
        state_q   <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (dump_req && !cpu_executing) begin
              if (dump_len == 16'd0) begin
                done_q <= 1'b1;
              end else begin
                addr_q      <= dump_base;
                remaining_q <= dump_len;
                line_ctr_q  <= '0;
                busy_q      <= 1'b1;
                state_q     <= S_RD_WAIT;
              end
            end
          end
          // Two cycles from address update to sampling covers the SPRAM read path.
          S_RD_WAIT:  state_q <= S_RD_LATCH;
          S_RD_LATCH: begin
            byte_q  <= tape_cell;
            state_q <= S_HI;
          end
          S_HI: if (char_accepted) state_q <= S_LO;
          S_LO: if (char_accepted) state_q <= S_SEP;
          S_SEP, S_LF: begin
            if (char_accepted) begin
              if (state_q == S_SEP && eol) begin
                state_q <= S_LF;
              end else begin
                addr_q      <= addr_q + 15'd1;
                remaining_q <= remaining_q - 16'd1;
                line_ctr_q  <= (line_ctr_q == LAST_COL) ? 8'd0 : line_ctr_q + 8'd1;
                if (remaining_q == 16'd1) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
                end else begin
                  state_q <= S_RD_WAIT;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  tx_char_sender u_sender (
    .clk             (clk),
    .rst             (rst),
    .char_valid_i    (char_valid),
    .char_i          (char_d),
    .hold_i          (cpu_executing),
    .tx_busy_i       (tx_busy),
    .tx_start_o      (tx_start),
    .tx_data_o       (tx_data),
    .char_accepted_o (char_accepted)
  );

  assign tape_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_tape_dumper.sv
// Directed bench for tape_dumper: two instances (16 and 2 bytes per line)
// share stimulus; each has its own tape read model and UART busy model.
module tb_tape_dumper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_req = 1'b0;
  logic [14:0] dump_base = '0;
  logic [15:0] dump_len = '0;
  logic        cpu_executing = 1'b0;
  logic        force_busy = 1'b0;

  logic [14:0] addr16, addr2;
  logic [7:0]  cell16, cell2;
  logic        start16, start2, txb16, txb2;
  logic [7:0]  data16, data2;
  logic        busy16, busy2, done16, done2, ab16, ab2;
  logic [2:0]  cnt16, cnt2;

  logic [7:0]  mem [0:32767];

  int errors = 0;
  int checks = 0;

  logic [7:0]  q16[$], q2[$];
  logic [14:0] alog[$];
  logic [14:0] last_addr = '0;
  int dn16 = 0, dn2 = 0, abc16 = 0, bh16 = 0, viol16 = 0, viol2 = 0;

  always #5 clk = ~clk;

  tape_dumper #(.BYTES_PER_LINE(16)) u16 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .dump_base(dump_base), .dump_len(dump_len),
    .cpu_executing(cpu_executing), .tape_addr(addr16), .tape_cell(cell16), .tx_start(start16),
    .tx_data(data16), .tx_busy(txb16), .busy(busy16), .done(done16), .aborted(ab16));

  tape_dumper #(.BYTES_PER_LINE(2)) u2 (
    .clk(clk), .rst(rst), .dump_req(dump_req), .dump_base(dump_base), .dump_len(dump_len),
    .cpu_executing(cpu_executing), .tape_addr(addr2), .tape_cell(cell2), .tx_start(start2),
    .tx_data(data2), .tx_busy(txb2), .busy(busy2), .done(done2), .aborted(ab2));

  // Tape read returns data one clock after the address is presented.
  always @(posedge clk) begin
    cell16 <= mem[addr16];
    cell2  <= mem[addr2];
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt16 <= '0;
      cnt2  <= '0;
    end else begin
      if (start16) cnt16 <= 3'd4; else if (cnt16 != 0) cnt16 <= cnt16 - 3'd1;
      if (start2)  cnt2  <= 3'd4; else if (cnt2 != 0)  cnt2  <= cnt2 - 3'd1;
    end
  end
  assign txb16 = force_busy | (cnt16 != 0);
  assign txb2  = force_busy | (cnt2 != 0);

  always @(negedge clk) begin
    if (start16) begin q16.push_back(data16); if (txb16) viol16++; end
    if (start2)  begin q2.push_back(data2);   if (txb2)  viol2++;  end
    if (done16) dn16++;
    if (done2)  dn2++;
    if (ab16)   abc16++;
    if (busy16) bh16++;
    if (addr16 != last_addr) begin alog.push_back(addr16); last_addr = addr16; end
  end

  function automatic string esc(input logic [7:0] c);
    if (c == 8'h0D) return "\\r";
    if (c == 8'h0A) return "\\n";
    return $sformatf("%c", c);
  endfunction

  function automatic string str16(input int from);
    string s = "";
    for (int i = from; i < q16.size(); i++) s = {s, esc(q16[i])};
    return s;
  endfunction

  function automatic string str2(input int from);
    string s = "";
    for (int i = from; i < q2.size(); i++) s = {s, esc(q2[i])};
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [14:0] b, input logic [15:0] l);
    dump_base = b;
    dump_len  = l;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
  endtask

  task automatic wait_done(input int d16, input int d2);
    for (int i = 0; i < 3000 && (dn16 == d16 || dn2 == d2); i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (addr16 !== 15'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", addr16); end
    checks++; if (start16 !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", start16); end
    checks++; if (data16 !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", data16); end
    checks++; if ({busy16, done16, ab16} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy16, done16, ab16}); end
    rst = 1'b0;
    tick();
    checks++; if ({busy2, done2, ab2, start2} !== 4'b0000) begin errors++; $display("FAIL reset_u2_flags got=%b exp=0000", {busy2, done2, ab2, start2}); end
  endtask

  task automatic test_basic();
    int s16 = q16.size(), s2 = q2.size(), d16 = dn16, d2 = dn2;
    mem[0] = 8'h00; mem[1] = 8'h4A; mem[2] = 8'hFF;
    pulse_req(15'h0000, 16'd3);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL basic_busy_start got=%b exp=1", busy16); end
    wait_done(d16, d2);
    repeat (10) tick();
    checks++; if (str16(s16) != "00 4A FF\\r\\n") begin errors++; $display("FAIL basic_stream16 got=\"%s\" exp=\"00 4A FF\\r\\n\"", str16(s16)); end
    checks++; if (str2(s2) != "00 4A\\r\\nFF\\r\\n") begin errors++; $display("FAIL basic_stream2 got=\"%s\" exp=\"00 4A\\r\\nFF\\r\\n\"", str2(s2)); end
    checks++; if (dn16 - d16 != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dn16 - d16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy16); end
  endtask

  task automatic test_bpl2();
    int s16 = q16.size(), s2 = q2.size(), d16 = dn16, d2 = dn2;
    mem[15'h100] = 8'h01; mem[15'h101] = 8'h02; mem[15'h102] = 8'h03;
    pulse_req(15'h0100, 16'd3);
    wait_done(d16, d2);
    repeat (10) tick();
    checks++; if (str2(s2) != "01 02\\r\\n03\\r\\n") begin errors++; $display("FAIL bpl2_stream got=\"%s\" exp=\"01 02\\r\\n03\\r\\n\"", str2(s2)); end
    checks++; if (str16(s16) != "01 02 03\\r\\n") begin errors++; $display("FAIL bpl2_stream16 got=\"%s\" exp=\"01 02 03\\r\\n\"", str16(s16)); end
    checks++; if (dn2 - d2 != 1) begin errors++; $display("FAIL bpl2_done_count got=%0d exp=1", dn2 - d2); end
  endtask

  task automatic test_wrap();
    int s16 = q16.size(), a0 = alog.size(), d16 = dn16, d2 = dn2;
    mem[15'h7FFF] = 8'hAB; mem[15'h0000] = 8'hCD;
    pulse_req(15'h7FFF, 16'd2);
    wait_done(d16, d2);
    repeat (10) tick();
    checks++; if (alog.size() < a0 + 2 || alog[a0] !== 15'h7FFF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=7fff", (alog.size() > a0) ? alog[a0] : 15'h0); end
    checks++; if (alog.size() < a0 + 2 || alog[a0+1] !== 15'h0000) begin errors++; $display("FAIL wrap_addr1 got=%h exp=0000", (alog.size() > a0 + 1) ? alog[a0+1] : 15'h7FFF); end
    checks++; if (str16(s16) != "AB CD\\r\\n") begin errors++; $display("FAIL wrap_stream got=\"%s\" exp=\"AB CD\\r\\n\"", str16(s16)); end
  endtask

  task automatic test_len0();
    int s16 = q16.size(), b = bh16, d16 = dn16;
    pulse_req(15'h0040, 16'd0);
    checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL len0_done got=%b exp=1", done16); end
    repeat (20) tick();
    checks++; if (dn16 - d16 != 1) begin errors++; $display("FAIL len0_done_count got=%0d exp=1", dn16 - d16); end
    checks++; if (q16.size() != s16) begin errors++; $display("FAIL len0_no_tx got=%0d exp=0 chars", q16.size() - s16); end
    checks++; if (bh16 != b) begin errors++; $display("FAIL len0_busy got=%0d exp=0 busy cycles", bh16 - b); end
  endtask

  task automatic test_tx_busy_hold();
    int s16 = q16.size(), d16 = dn16, d2 = dn2;
    mem[15'h200] = 8'h5C; mem[15'h201] = 8'h07; mem[15'h300] = 8'hEE;
    force_busy = 1'b1;
    pulse_req(15'h0200, 16'd2);
    repeat (50) tick();
    pulse_req(15'h0300, 16'd1);
    repeat (49) tick();
    checks++; if (q16.size() != s16) begin errors++; $display("FAIL hold_no_tx got=%0d exp=0 chars", q16.size() - s16); end
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b exp=1", busy16); end
    force_busy = 1'b0;
    wait_done(d16, d2);
    repeat (10) tick();
    checks++; if (str16(s16) != "5C 07\\r\\n") begin errors++; $display("FAIL hold_stream got=\"%s\" exp=\"5C 07\\r\\n\"", str16(s16)); end
  endtask

  task automatic test_abort();
    int s16 = q16.size(), a = abc16, d16 = dn16;
    mem[15'h300] = 8'h3C; mem[15'h301] = 8'h11; mem[15'h302] = 8'h22;
    pulse_req(15'h0300, 16'd3);
    for (int i = 0; i < 2000 && q16.size() < s16 + 2; i++) tick();
    checks++; if (q16.size() != s16 + 2) begin errors++; $display("FAIL abort_wait got=%0d exp=2 chars", q16.size() - s16); end
    cpu_executing = 1'b1;
    tick();
    checks++; if ({ab16, busy16} !== 2'b10) begin errors++; $display("FAIL abort_pulse got=%b exp=10", {ab16, busy16}); end
    repeat (40) tick();
    checks++; if (str16(s16) != "3C") begin errors++; $display("FAIL abort_stream got=\"%s\" exp=\"3C\"", str16(s16)); end
    checks++; if (abc16 - a != 1 || dn16 != d16) begin errors++; $display("FAIL abort_counts got=%0d/%0d exp=1/0", abc16 - a, dn16 - d16); end
    pulse_req(15'h0300, 16'd3);
    tick();
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL req_while_exec got=%b exp=0", busy16); end
    cpu_executing = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_rst_mid();
    int s16 = q16.size();
    mem[15'h400] = 8'h9A;
    pulse_req(15'h0400, 16'd4);
    for (int i = 0; i < 2000 && q16.size() == s16; i++) tick();
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got=%b exp=1", busy16); end
    rst = 1'b1;
    tick();
    checks++; if ({addr16, data16, start16, busy16, done16, ab16} !== 27'h0) begin
      errors++; $display("FAIL rst_mid_outputs addr=%h data=%h flags=%b exp=all 0", addr16, data16, {start16, busy16, done16, ab16});
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bpl2();
    test_wrap();
    test_len0();
    test_tx_busy_hold();
    test_abort();
    test_rst_mid();
    checks++; if (viol16 != 0 || viol2 != 0) begin errors++; $display("FAIL start_while_busy got=%0d/%0d exp=0/0", viol16, viol2); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
